// File: rtl/gd_sweep_pkg.sv
// rtl/gd_sweep_pkg.sv - shared types, constants and helpers for the gradient-descent sweep driver
//
// Contents:
//   sweep_state_e       : sequencer FSM states
//   Q_FRAC_BITS/Q_WIDTH : Q24.8 fixed-point format
//   DEF_*               : default expected minimum, tolerance and start-point step
//   OVF_*               : bit positions inside the core's ovf_flags vector
//   ovf_any, sat_inc16  : helper functions
package gd_sweep_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_ISSUE   = 3'd1,
    ST_CHECK   = 3'd2,
    ST_RELEASE = 3'd3,
    ST_FINISH  = 3'd4
  } sweep_state_e;

  localparam int unsigned Q_FRAC_BITS = 8;
  localparam int unsigned Q_WIDTH     = 24 + Q_FRAC_BITS;

  localparam logic [31:0] DEF_OFFSET    = 32'h0000_0400;  // 4.0
  localparam logic [31:0] DEF_TOLERANCE = 32'h0000_0019;  // 25/256
  localparam logic [31:0] DEF_INCREMENT = 32'h0000_0001;  // 1/256

  // ovf_flags = {gradient, x_sqr, x_diff, init_x_square}
  localparam int unsigned OVF_INIT_X_SQUARE = 0;
  localparam int unsigned OVF_X_DIFF        = 1;
  localparam int unsigned OVF_X_SQR         = 2;
  localparam int unsigned OVF_GRADIENT      = 3;

  function automatic logic ovf_any(input logic [3:0] flags);
    return flags[OVF_GRADIENT] | flags[OVF_X_SQR] | flags[OVF_X_DIFF] | flags[OVF_INIT_X_SQUARE];
  endfunction

  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

endpackage

// File: rtl/gd_sweep_driver_if.sv
// rtl/gd_sweep_driver_if.sv - start/done handshake between the sweep driver and the gradient-descent core
//
// Signals:
//   start_op     : request from driver, held high until done_op is seen
//   initial_x_in : Q24.8 start point, stable while start_op is high
//   done_op      : completion from core
//   x_at_min     : Q24.8 converged location
//   y_min        : 56-bit minimum value
//   ovf_flags    : {gradient, x_sqr, x_diff, init_x_square} overflow flags
// Modports: master (sweep driver side), slave (core side).
interface gd_sweep_driver_if;
  logic        start_op;
  logic [31:0] initial_x_in;
  logic        done_op;
  logic [31:0] x_at_min;
  logic [55:0] y_min;
  logic [3:0]  ovf_flags;

  modport master (
    output start_op, initial_x_in,
    input  done_op, x_at_min, y_min, ovf_flags
  );

  modport slave (
    input  start_op, initial_x_in,
    output done_op, x_at_min, y_min, ovf_flags
  );
endinterface

// File: rtl/q24_8_tol_check.sv
// rtl/q24_8_tol_check.sv - combinational |x_cap - OFFSET| <= TOLERANCE compare on Q24.8 values
//
// Parameters: OFFSET (expected minimum, signed Q24.8), TOLERANCE (unsigned Q24.8 bound)
// Ports:
//   x_cap  in  : signed Q24.8 value under test
//   in_tol out : 1 when the absolute distance to OFFSET is within TOLERANCE
module q24_8_tol_check
  import gd_sweep_pkg::*;
#(
  parameter logic [31:0] OFFSET    = DEF_OFFSET,
  parameter logic [31:0] TOLERANCE = DEF_TOLERANCE
) (
  input  logic [Q_WIDTH-1:0] x_cap,
  output logic               in_tol
);

  logic [32:0] diff;
  logic [32:0] mag;

  // 33 bits hold any difference of two signed 32-bit values, so the
  // magnitude below never overflows (its largest value is 2^32 - 1).
  always_comb begin
    diff   = {x_cap[Q_WIDTH-1], x_cap} - {OFFSET[31], OFFSET};
    mag    = diff[32] ? (33'd0 - diff) : diff;
    in_tol = (mag <= {1'b0, TOLERANCE});
  end

endmodule

// File: rtl/gd_sweep_driver.sv
// rtl/gd_sweep_driver.sv - sequencer that sweeps the gradient-descent core over start points and scores results
//
// Build option: GD_SWEEP_STOP_ON_FAIL_EN - when defined, the sweep ends after the first failing run.
//
// Ports:
//   clk, rst_n        : clock, asynchronous active-low reset
//   sweep_start       : begin a sweep (sampled in IDLE only)
//   base_x            : first Q24.8 start point, captured with sweep_start
//   core              : master side of the core start/done handshake
//   sweep_busy        : high from the cycle after sweep_start until FINISH
//   sweep_done        : one-cycle pulse at sweep end
//   pass_count        : saturating count of passing runs
//   fail_count        : saturating count of failing runs (including a timeout)
//   first_fail_*      : index, start point, x_at_min and y_min of the first failure
//   timeout_err       : core never answered; sticky until next sweep_start
module gd_sweep_driver
  import gd_sweep_pkg::*;
#(
  parameter int unsigned LOOP_COUNT     = 10,
  parameter logic [31:0] INCREMENT      = DEF_INCREMENT,
  parameter logic [31:0] OFFSET         = DEF_OFFSET,
  parameter logic [31:0] TOLERANCE      = DEF_TOLERANCE,
  parameter int unsigned GAP_CYCLES     = 2,
  parameter int unsigned TIMEOUT_CYCLES = 1024
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                sweep_start,
  input  logic [31:0]         base_x,
  gd_sweep_driver_if.master   core,
  output logic                sweep_busy,
  output logic                sweep_done,
  output logic [15:0]         pass_count,
  output logic [15:0]         fail_count,
  output logic                first_fail_valid,
  output logic [15:0]         first_fail_idx,
  output logic [31:0]         first_fail_x_init,
  output logic [31:0]         first_fail_x_min,
  output logic [55:0]         first_fail_y_min,
  output logic                timeout_err
);

`ifdef GD_SWEEP_STOP_ON_FAIL_EN
  localparam bit STOP_ON_FAIL = 1'b1;
`else
  localparam bit STOP_ON_FAIL = 1'b0;
`endif

  localparam logic [15:0] LOOP_LAST    = 16'(LOOP_COUNT);
  localparam logic [31:0] TIMEOUT_LAST = 32'(TIMEOUT_CYCLES - 1);
  localparam logic [31:0] GAP_LAST     = 32'(GAP_CYCLES - 1);

  sweep_state_e state_q, state_d;
  logic        start_op_q, start_op_d;
  logic [31:0] initial_x_in_q, initial_x_in_d;
  logic [31:0] cur_x_q, cur_x_d;
  logic [15:0] idx_q, idx_d;
  logic [31:0] wait_cnt_q, wait_cnt_d;
  logic [31:0] gap_cnt_q, gap_cnt_d;
  logic [31:0] x_cap_q, x_cap_d;
  logic [55:0] y_cap_q, y_cap_d;
  logic [3:0]  ovf_cap_q, ovf_cap_d;
  logic        sweep_busy_q, sweep_busy_d;
  logic        sweep_done_q, sweep_done_d;
  logic [15:0] pass_count_q, pass_count_d;
  logic [15:0] fail_count_q, fail_count_d;
  logic        ff_valid_q, ff_valid_d;
  logic [15:0] ff_idx_q, ff_idx_d;
  logic [31:0] ff_x_init_q, ff_x_init_d;
  logic [31:0] ff_x_min_q, ff_x_min_d;
  logic [55:0] ff_y_min_q, ff_y_min_d;
  logic        timeout_err_q, timeout_err_d;

  logic        in_tol;
  logic        run_pass;
  logic [15:0] idx_inc;
  logic [31:0] cur_x_inc;

  q24_8_tol_check #(
    .OFFSET    (OFFSET),
    .TOLERANCE (TOLERANCE)
  ) u_tol_check (
    .x_cap  (x_cap_q),
    .in_tol (in_tol)
  );

  assign run_pass  = in_tol && !ovf_any(ovf_cap_q);
  assign idx_inc   = idx_q + 16'd1;
  assign cur_x_inc = cur_x_q + INCREMENT;  // wraps mod 2^32 by construction

  always_comb begin
    state_d        = state_q;
    start_op_d     = start_op_q;
    initial_x_in_d = initial_x_in_q;
    cur_x_d        = cur_x_q;
    idx_d          = idx_q;
    wait_cnt_d     = wait_cnt_q;
    gap_cnt_d      = gap_cnt_q;
    x_cap_d        = x_cap_q;
    y_cap_d        = y_cap_q;
    ovf_cap_d      = ovf_cap_q;
    sweep_busy_d   = sweep_busy_q;
    sweep_done_d   = 1'b0;
    pass_count_d   = pass_count_q;
    fail_count_d   = fail_count_q;
    ff_valid_d     = ff_valid_q;
    ff_idx_d       = ff_idx_q;
    ff_x_init_d    = ff_x_init_q;
    ff_x_min_d     = ff_x_min_q;
    ff_y_min_d     = ff_y_min_q;
    timeout_err_d  = timeout_err_q;

    case (state_q)
      ST_IDLE: begin
        if (sweep_start) begin
          pass_count_d   = '0;
          fail_count_d   = '0;
          ff_valid_d     = 1'b0;
          ff_idx_d       = '0;
          ff_x_init_d    = '0;
          ff_x_min_d     = '0;
          ff_y_min_d     = '0;
          timeout_err_d  = 1'b0;
          cur_x_d        = base_x;
          idx_d          = '0;
          wait_cnt_d     = '0;
          start_op_d     = 1'b1;
          initial_x_in_d = base_x;
          sweep_busy_d   = 1'b1;
          state_d        = ST_ISSUE;
        end
      end

      ST_ISSUE: begin
        if (core.done_op) begin
          x_cap_d    = core.x_at_min;
          y_cap_d    = core.y_min;
          ovf_cap_d  = core.ovf_flags;
          start_op_d = 1'b0;
          state_d    = ST_CHECK;
        end else if (wait_cnt_q >= TIMEOUT_LAST) begin
          // No answer: the core state is unknown, so the rest of the sweep is abandoned.
          timeout_err_d = 1'b1;
          fail_count_d  = sat_inc16(fail_count_q);
          if (!ff_valid_q) begin
            ff_valid_d  = 1'b1;
            ff_idx_d    = idx_q;
            ff_x_init_d = cur_x_q;
            ff_x_min_d  = core.x_at_min;
            ff_y_min_d  = core.y_min;
          end
          start_op_d   = 1'b0;
          sweep_busy_d = 1'b0;
          sweep_done_d = 1'b1;
          state_d      = ST_FINISH;
        end else begin
          wait_cnt_d = wait_cnt_q + 32'd1;
        end
      end

      ST_CHECK: begin
        if (run_pass) begin
          pass_count_d = sat_inc16(pass_count_q);
        end else begin
          fail_count_d = sat_inc16(fail_count_q);
          if (!ff_valid_q) begin
            ff_valid_d  = 1'b1;
            ff_idx_d    = idx_q;
            ff_x_init_d = cur_x_q;
            ff_x_min_d  = x_cap_q;
            ff_y_min_d  = y_cap_q;
          end
        end
        gap_cnt_d = '0;
        state_d   = ST_RELEASE;
      end

      ST_RELEASE: begin
        // gap_cnt_q counts RELEASE cycles already completed; the current one is gap_cnt_q + 1.
        if (gap_cnt_q < GAP_LAST) begin
          gap_cnt_d = gap_cnt_q + 32'd1;
        end
        if (!core.done_op && (gap_cnt_q >= GAP_LAST)) begin
          cur_x_d = cur_x_inc;
          idx_d   = idx_inc;
          if ((idx_inc == LOOP_LAST) || (STOP_ON_FAIL && ff_valid_q)) begin
            sweep_busy_d = 1'b0;
            sweep_done_d = 1'b1;
            state_d      = ST_FINISH;
          end else begin
            wait_cnt_d     = '0;
            start_op_d     = 1'b1;
            initial_x_in_d = cur_x_inc;
            state_d        = ST_ISSUE;
          end
        end
      end

      ST_FINISH: begin
        state_d = ST_IDLE;
      end

      default: begin
        start_op_d   = 1'b0;
        sweep_busy_d = 1'b0;
        state_d      = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= ST_IDLE;
      start_op_q     <= 1'b0;
      initial_x_in_q <= '0;
      cur_x_q        <= '0;
      idx_q          <= '0;
      wait_cnt_q     <= '0;
      gap_cnt_q      <= '0;
      x_cap_q        <= '0;
      y_cap_q        <= '0;
      ovf_cap_q      <= '0;
      sweep_busy_q   <= 1'b0;
      sweep_done_q   <= 1'b0;
      pass_count_q   <= '0;
      fail_count_q   <= '0;
      ff_valid_q     <= 1'b0;
      ff_idx_q       <= '0;
      ff_x_init_q    <= '0;
      ff_x_min_q     <= '0;
      ff_y_min_q     <= '0;
      timeout_err_q  <= 1'b0;
    end else begin
      state_q        <= state_d;
      start_op_q     <= start_op_d;
      initial_x_in_q <= initial_x_in_d;
      cur_x_q        <= cur_x_d;
      idx_q          <= idx_d;
      wait_cnt_q     <= wait_cnt_d;
      gap_cnt_q      <= gap_cnt_d;
      x_cap_q        <= x_cap_d;
      y_cap_q        <= y_cap_d;
      ovf_cap_q      <= ovf_cap_d;
      sweep_busy_q   <= sweep_busy_d;
      sweep_done_q   <= sweep_done_d;
      pass_count_q   <= pass_count_d;
      fail_count_q   <= fail_count_d;
      ff_valid_q     <= ff_valid_d;
      ff_idx_q       <= ff_idx_d;
      ff_x_init_q    <= ff_x_init_d;
      ff_x_min_q     <= ff_x_min_d;
      ff_y_min_q     <= ff_y_min_d;
      timeout_err_q  <= timeout_err_d;
    end
  end

  assign core.start_op     = start_op_q;
  assign core.initial_x_in = initial_x_in_q;
  assign sweep_busy        = sweep_busy_q;
  assign sweep_done        = sweep_done_q;
  assign pass_count        = pass_count_q;
  assign fail_count        = fail_count_q;
  assign first_fail_valid  = ff_valid_q;
  assign first_fail_idx    = ff_idx_q;
  assign first_fail_x_init = ff_x_init_q;
  assign first_fail_x_min  = ff_x_min_q;
  assign first_fail_y_min  = ff_y_min_q;
  assign timeout_err       = timeout_err_q;

endmodule

// File: doc/gd_sweep_driver.md
# gd_sweep_driver

Hardware sequencer that drives the fixed-point gradient-descent core through its start/done handshake. It issues `LOOP_COUNT` runs from successive Q24.8 start points, checks each converged `x_at_min` against the expected minimum, and reports pass/fail statistics plus the first failing case. It sits on the initiator side of the core's `start_op`/`done_op` interface and is used for on-chip self-test and sweep characterisation.

## Interface
- `LOOP_COUNT`, 10: runs per sweep (≥1)
- `INCREMENT`, 32'h00000001: Q24.8 step added to the start point after each run
- `OFFSET`, 32'h00000400: expected minimum location, Q24.8 (4.0)
- `TOLERANCE`, 32'h00000019: max allowed |x_at_min − OFFSET|, Q24.8 (25/256 ≈ 0.098)
- `GAP_CYCLES`, 2: minimum idle cycles with `start_op` low between runs (≥1)
- `TIMEOUT_CYCLES`, 1024: max cycles to wait for `done_op`

- `clk` in 1: clock
- `rst_n` in 1: asynchronous active-low reset
- `sweep_start` in 1: begin sweep; sampled in IDLE only
- `base_x` in 32: signed Q24.8 first start point, captured on `sweep_start`
- `start_op` out 1: core request
- `initial_x_in` out 32: signed Q24.8 start point to core
- `done_op` in 1: core completion
- `x_at_min` in 32: signed Q24.8 core result
- `y_min` in 56: core minimum value (captured, reported on failure)
- `ovf_flags` in 4: {gradient, x_sqr, x_diff, init_x_square} overflow flags
- `sweep_busy` out 1: high from the cycle after `sweep_start` until FINISH
- `sweep_done` out 1: one-cycle pulse at sweep end
- `pass_count` out 16, `fail_count` out 16: per-sweep counters
- `first_fail_valid` out 1; `first_fail_idx` out 16; `first_fail_x_init` out 32; `first_fail_x_min` out 32; `first_fail_y_min` out 56
- `timeout_err` out 1: sticky until next `sweep_start`

## Operation
- FSM states: IDLE, ISSUE, CHECK, RELEASE, FINISH.
- IDLE: on `sweep_start`, clear counters, first-fail record and `timeout_err`; load `cur_x`=`base_x`, `idx`=0; go to ISSUE.
- ISSUE: `start_op`=1 and `initial_x_in`=`cur_x`, both held stable. The cycle `done_op` is sampled high, capture `x_at_min`, `y_min` and `ovf_flags`; go to CHECK. If the wait counter reaches `TIMEOUT_CYCLES`, set `timeout_err`, increment `fail_count`, record first-fail if none exists, drop `start_op`, and go to FINISH. A timeout always aborts the sweep.
- CHECK: diff = sign-extended 33-bit (`x_cap` − `OFFSET`), then absolute value. Pass iff |diff| ≤ `TOLERANCE` and the captured `ovf_flags` are all 0. Update the pass or fail counter. On the first fail, latch `idx`, `cur_x`, `x_cap` and `y_cap`, and set `first_fail_valid`. Go to RELEASE.
- RELEASE: `start_op`=0. Stay until `done_op`=0 and at least `GAP_CYCLES` cycles have elapsed in this state. Then `cur_x` += `INCREMENT`, wrapping mod 2^32, and `idx`++. If `idx`==`LOOP_COUNT`, go to FINISH; otherwise go to ISSUE.
- FINISH: pulse `sweep_done` for one cycle, deassert `sweep_busy`, return to IDLE.
- `sweep_start` outside IDLE is ignored.
- Counters saturate at 16'hFFFF.

## Timing
- Reset values: all outputs 0. FSM in IDLE, `start_op`=0.
- Reset asserted mid-run drops `start_op` immediately (asynchronously). The run is discarded.
- Latency from `sweep_start` to the first `start_op` rising edge: 1 cycle.
- Per run: core latency + 1 (CHECK) + max(`GAP_CYCLES`, cycles until `done_op` falls).
- `done_op` already high on entry to ISSUE is accepted on the first ISSUE cycle. This is legal only if the core has reasserted it for this request.
- `done_op` high while in IDLE or FINISH is ignored.
- Captured results reflect the cycle `done_op` is first sampled high.

## Configuration
- `GD_SWEEP_STOP_ON_FAIL_EN` defined: the first CHECK failure goes to RELEASE and then to FINISH regardless of `idx`. `pass_count` + `fail_count` equals the runs actually executed.
- Undefined: all `LOOP_COUNT` runs execute and every failure is counted. Timeout aborts in both builds.

## Structure
- Package `gd_sweep_pkg`:
  - state enum;
  - `Q_FRAC_BITS`=8;
  - default `OFFSET`/`TOLERANCE`/`INCREMENT` constants;
  - overflow-flag bit indices.
- One sub-module, `q24_8_tol_check`: combinational 33-bit abs-diff compare of `x_cap` against `OFFSET`/`TOLERANCE`, producing `in_tol`.

## Test plan
- Ideal core model (returns 32'h400 after 5 cycles), `base_x`=32'h400003F8, `LOOP_COUNT`=10 → `pass_count`=10, `fail_count`=0, one `sweep_done` pulse, `initial_x_in` values 32'h400003F8..32'h40000401.
- Model returns 32'h41A (|diff|=26) on run 3 → `fail_count`=1, `first_fail_idx`=3, `first_fail_x_init`=32'h400003FB, `first_fail_x_min`=32'h41A. With `GD_SWEEP_STOP_ON_FAIL_EN`, `pass_count`=3 and the sweep ends after run 3.
- Model returns 32'h419 (|diff|=25) → pass. Model returns 32'h3E6 (|diff|=26, negative side) → fail.
- Model raises `ovf_flags`=4'b0100 with `x_at_min`=32'h400 → run counted as fail.
- Model never asserts `done_op` with `TIMEOUT_CYCLES`=16 → `timeout_err`=1, `fail_count`=1, `sweep_done` pulses, `start_op` low.
- `base_x`=32'h7FFFFFFF, `INCREMENT`=1, 2 runs → second `initial_x_in`=32'h80000000. `rst_n` pulled low mid-ISSUE → `start_op`=0 immediately, all outputs 0.
